fetch_pc: RTL
=============

FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 SHALL provide parameter: RESET_PC, 32'd0, PC value loaded on reset.
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL provide port: npc_in  input  32  incremented PC (pc_out+1) from the incrementer stage.
REQ-005 SHALL provide port: pcsrc  input  1  1 = redirect to branch_target.
REQ-006 SHALL provide port: branch_target  input  32  redirect address (word address).
REQ-007 SHALL provide port: stall  input  1  hazard stall from decode; hold PC and IF/ID.
REQ-008 SHALL provide port: flush  input  1  squash the instruction entering IF/ID.
REQ-009 SHALL provide port: instr_in  input  32  instruction word from instruction memory.
REQ-010 SHALL provide port: imem_ready  input  1  instr_in valid for current pc_out.
REQ-011 SHALL provide port: pc_out  output  32  current PC; drives incrementer and imem address.
REQ-012 SHALL provide port: imem_req  output  1  fetch request for pc_out.
REQ-013 SHALL provide port: ifid_instr  output  32  IF/ID instruction register.
REQ-014 SHALL provide port: ifid_npc  output  32  IF/ID next-PC register.
REQ-015 SHALL provide port: ifid_valid  output  1  IF/ID contents valid (0 = bubble).

Function
REQ-016 SHALL implement a two-state FSM: FETCH (imem_req=1) and HOLD (imem_req=0); all outputs registered except imem_req, which is decoded from the state.
REQ-017 SHALL use the following update priority each cycle: reset > redirect (pcsrc) > flush > stall > normal fetch.
REQ-018 Normal fetch: in FETCH with stall=0, imem_ready=1, pcsrc=0 -> next cycle pc_out=npc_in, ifid_instr=instr_in, ifid_npc=npc_in, ifid_valid=1; one-cycle latency fetch-to-IF/ID.
REQ-019 Memory wait: in FETCH with stall=0, imem_ready=0, pcsrc=0 -> pc_out held, ifid_valid=0 (bubble), ifid_instr/ifid_npc held, remain in FETCH.
REQ-020 Stall: stall=1, pcsrc=0, flush=0 -> pc_out, ifid_instr, ifid_npc, ifid_valid all held; state -> HOLD; imem_ready ignored.
REQ-021 HOLD -> FETCH on the first cycle stall=0; same-cycle imem_ready is ignored and the fetch at held pc_out restarts the next cycle.
REQ-022 Redirect: pcsrc=1 -> pc_out=branch_target next cycle regardless of stall, imem_ready or state; ifid_valid=0, ifid_instr=32'd0; state -> FETCH.
REQ-023 Flush: flush=1, pcsrc=0 -> ifid_valid=0, ifid_instr=32'd0 next cycle; pc_out advances per REQ-018/019 if stall=0, else held.
REQ-024 PC arithmetic is word-addressed; npc_in is used unchanged; 32'hFFFFFFFF -> 32'h00000000 wrap accepted with no flag.
REQ-025 An instruction SHALL never be latched into IF/ID with ifid_valid=1 unless imem_ready=1 in the same cycle.

Reset
REQ-026 When rst_n=0 at a rising edge: pc_out=RESET_PC, ifid_instr=0, ifid_npc=0, ifid_valid=0, state=FETCH.
REQ-027 imem_req SHALL be 0 while rst_n=0 and SHALL be 1 in the first cycle after release.
REQ-028 Reset asserted mid-stall, mid-wait or coincident with pcsrc SHALL override all other inputs; no partial update survives.

Verification
REQ-029 Reset then imem_ready=1 for 3 cycles, instr 0xA0,0xA1,0xA2 -> pc_out 0,1,2,3; ifid_npc 1,2,3; ifid_valid=1 from cycle 1.
REQ-030 pc_out=5, imem_ready=0 for 2 cycles then 1 -> pc_out stays 5, ifid_valid=0 for 2 cycles, then IF/ID holds instr with ifid_npc=6.
REQ-031 pc_out=8 with stall=1 for 3 cycles -> pc_out=8, IF/ID unchanged, imem_req=0; one cycle after stall drops, imem_req=1.
REQ-032 pcsrc=1, branch_target=0x40, stall=1, flush=1 same cycle -> next pc_out=0x40, ifid_valid=0, ifid_instr=0.
REQ-033 pc_out=0xFFFFFFFF, npc_in=0, imem_ready=1 -> next pc_out=0, ifid_npc=0, ifid_valid=1.
REQ-034 rst_n=0 asserted during HOLD with pc_out=0x20 -> next cycle pc_out=RESET_PC, ifid_valid=0, imem_req=0.

Source files
------------

// File: rtl/fetch_pc.sv
// Fetch-stage program counter and IF/ID pipeline register.
// Two-state fetch control: FETCH issues imem requests, HOLD parks the PC during decode stalls.
module fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc_in,
  input  logic        pcsrc,
  input  logic [31:0] branch_target,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic        imem_ready,
  output logic [31:0] pc_out,
  output logic        imem_req,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] r_ifid_instr;
  logic [31:0] w_ifid_instr_next;
  logic [31:0] r_ifid_npc;
  logic [31:0] w_ifid_npc_next;
  logic        r_ifid_valid;
  logic        w_ifid_valid_next;
  logic        w_fetch_ok;

  // A fetch completes only in FETCH with memory ready; HOLD exit always costs one cycle.
  assign w_fetch_ok = (r_state == S_FETCH) && imem_ready;

  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_ifid_instr_next = r_ifid_instr;
    w_ifid_npc_next   = r_ifid_npc;
    w_ifid_valid_next = r_ifid_valid;

    if (pcsrc) begin
      w_pc_next         = branch_target;
      w_ifid_instr_next = 32'd0;
      w_ifid_valid_next = 1'b0;
      w_state_next      = S_FETCH;
    end else if (flush) begin
      w_ifid_instr_next = 32'd0;
      w_ifid_valid_next = 1'b0;
      if (stall) begin
        w_state_next = S_HOLD;
      end else begin
        w_state_next = S_FETCH;
        if (w_fetch_ok) begin
          w_pc_next       = npc_in;
          w_ifid_npc_next = npc_in;
        end
      end
    end else if (stall) begin
      w_state_next = S_HOLD;
    end else if (r_state == S_HOLD) begin
      // Decode consumes the held entry this cycle, so IF/ID becomes a bubble.
      w_state_next      = S_FETCH;
      w_ifid_valid_next = 1'b0;
    end else if (imem_ready) begin
      w_pc_next         = npc_in;
      w_ifid_instr_next = instr_in;
      w_ifid_npc_next   = npc_in;
      w_ifid_valid_next = 1'b1;
    end else begin
      w_ifid_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_ifid_instr <= 32'd0;
      r_ifid_npc   <= 32'd0;
      r_ifid_valid <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_ifid_instr <= w_ifid_instr_next;
      r_ifid_npc   <= w_ifid_npc_next;
      r_ifid_valid <= w_ifid_valid_next;
    end
  end

  // Request is suppressed while reset is held so memory sees no fetch of a stale PC.
  assign imem_req   = rst_n && (r_state == S_FETCH);
  assign pc_out     = r_pc;
  assign ifid_instr = r_ifid_instr;
  assign ifid_npc   = r_ifid_npc;
  assign ifid_valid = r_ifid_valid;

endmodule
